// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-bus access stage used by the control unit during execute. Converts
//   the load/store strobes, f3 and the ALU address into one word-aligned,
//   byte-enabled req/ack bus transaction, holds stall until it completes and
//   returns sign/zero-extended load data that stays stable through write-back.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned H/HU/SH (addr[0]) and W/SW (addr[1:0]) accesses
//                 raise access_fault and never reach the bus.
//     undefined : H ignores addr[0], W ignores addr[1:0] (aligned-down access).
//
// Parameters
//   TIMEOUT_CYCLES : BUSY cycles without mem_ack before abort (0 = never).
//
// Ports
//   clk, rst        : clock, asynchronous active-low reset
//   exec, re, we    : execute state, load strobe, store strobe
//   f3              : width/sign (0 B, 1 H, 2 W, 4 BU, 5 HU)
//   addr, wdata     : byte address, store data
//   stall           : hold the control unit
//   rdata           : extended load result (held until next load completes)
//   access_fault    : one-cycle pulse for an illegal access
//   bus_error       : one-cycle pulse on timeout
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : bus request side
//   mem_ack/mem_rdata                         : bus response side
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exec,
    input  logic        re,
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        access_fault,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        starting;
    logic        legal;
    logic        misaligned;
    logic        tmo_hit;
    logic [1:0]  lane_off;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        load_q;
    logic [31:0] tmo_cnt;

    // f3/strobe legality, independent of alignment.
    function automatic logic f3_ok(input logic r, input logic w, input logic [2:0] f);
        logic ok;
        if (r && w)
            ok = 1'b0;
        else if (w)
            ok = (f <= 3'd2);
        else
            ok = (f != 3'd3) && (f != 3'd6) && (f != 3'd7);
        return ok;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << a;
            2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'd0:    r = {4{d[7:0]}};
            2'd1:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Bring the addressed lane down to bit 0, then extend by f3[2] (1 = zero).
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f);
        logic [31:0]        sh;
        logic signed [31:0] ext;
        sh = word >> {off, 3'b000};
        case (f[1:0])
            2'd0:    ext = f[2] ? $signed({24'd0, sh[7:0]})  : 32'($signed(sh[7:0]));
            2'd1:    ext = f[2] ? $signed({16'd0, sh[15:0]}) : 32'($signed(sh[15:0]));
            default: ext = $signed(sh);
        endcase
        return $unsigned(ext);
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((f3[1:0] == 2'd1) && addr[0]) ||
                        ((f3[1:0] == 2'd2) && (addr[1:0] != 2'd0));
`else
    assign misaligned = 1'b0;
`endif

    assign mem_req = (state == BUSY);

    always_comb begin
        starting  = (state == IDLE) && exec && (re || we);
        legal     = f3_ok(re, we, f3) && !misaligned;
        tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
        // Aligned-down byte offset of the accessed lane.
        case (f3[1:0])
            2'd0:    lane_off = addr[1:0];
            2'd1:    lane_off = {addr[1], 1'b0};
            default: lane_off = 2'd0;
        endcase
        state_nxt = state;
        case (state)
            IDLE:    if (starting) state_nxt = legal ? BUSY : DONE;
            BUSY:    if (mem_ack || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Gated by rst so an asynchronous reset releases the control unit at once.
        stall = rst && (starting || (state == BUSY));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---- request capture (IDLE) / completion (BUSY) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata        <= '0;
            access_fault <= 1'b0;
            bus_error    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            load_q       <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            access_fault <= starting && !legal;
            // mem_ack takes priority over an expiring timeout.
            bus_error    <= (state == BUSY) && !mem_ack && tmo_hit;
            if (starting && legal) begin
                mem_addr  <= {addr[31:2], 2'b00};
                mem_be    <= lane_be(f3[1:0], addr[1:0]);
                mem_we    <= we;
                mem_wdata <= lane_data(f3[1:0], wdata);
                off_q     <= lane_off;
                f3_q      <= f3;
                load_q    <= re;
                tmo_cnt   <= '0;
            end else if (state == BUSY) begin
                tmo_cnt   <= tmo_cnt + 32'd1;
            end
            if ((state == BUSY) && mem_ack && load_q)
                rdata <= extend_load(mem_rdata, off_q, f3_q);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vectors with a transaction-level
// model of the expected bus/stall/result behaviour, compared every cycle on
// the falling edge, plus literal expectations for the key vectors.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exec = 1'b0, re = 1'b0, we = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;

    logic        stall, access_fault, bus_error, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        exec4 = 1'b0, mem_ack4 = 1'b0;
    logic        stall4, access_fault4, bus_error4, mem_req4, mem_we4;
    logic [31:0] rdata4, mem_addr4, mem_wdata4;
    logic [3:0]  mem_be4;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bit          e_stall, e_req, e_we, e_fault, e_berr, e_wchk;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;

    load_store_unit #(.TIMEOUT_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .exec(exec), .re(re), .we(we), .f3(f3),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .access_fault(access_fault), .bus_error(bus_error), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .exec(exec4), .re(re), .we(we), .f3(f3),
        .addr(addr), .wdata(wdata), .stall(stall4), .rdata(rdata4),
        .access_fault(access_fault4), .bus_error(bus_error4), .mem_req(mem_req4),
        .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_be(mem_be4),
        .mem_wdata(mem_wdata4), .mem_ack(mem_ack4), .mem_rdata(mem_rdata));

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] f);
        return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic int m_off(input logic [2:0] f, input logic [31:0] a);
        int n = m_size(f);
        return (int'(a % 4) / n) * n;
    endfunction

    function automatic bit m_legal(input bit r, input bit w, input logic [2:0] f, input logic [31:0] a);
        if (r && w) return 1'b0;
        if (w && f > 3'd2) return 1'b0;
        if (!w && (f == 3'd3 || f >= 3'd6)) return 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((a % m_size(f)) != 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
        int n = m_size(f);
        return 4'(((1 << n) - 1) << m_off(f, a));
    endfunction

    function automatic logic [31:0] m_lanes(input logic [2:0] f, input logic [31:0] d);
        logic [31:0] r;
        int n = m_size(f);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] word);
        int     n   = m_size(f);
        longint big = longint'(1) << (8 * n);
        longint v   = (longint'(word) >> (8 * m_off(f, a))) % big;
        if (f < 3'd4 && n < 4 && v >= big / 2) v = v - big;
        return 32'(v);
    endfunction

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk1 ("stall",        stall,        e_stall);
            chk1 ("mem_req",      mem_req,      e_req);
            chk1 ("mem_we",       mem_we,       e_we);
            chk32("mem_addr",     mem_addr,     e_addr);
            chk32("mem_be",       {28'd0, mem_be}, {28'd0, e_be});
            chk32("rdata",        rdata,        e_rdata);
            chk1 ("access_fault", access_fault, e_fault);
            chk1 ("bus_error",    bus_error,    e_berr);
            if (e_wchk) chk32("mem_wdata", mem_wdata, e_wdata);
        end
    end

    task automatic model_reset();
        e_stall = 0; e_req = 0; e_we = 0; e_fault = 0; e_berr = 0; e_wchk = 1;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_be = '0;
    endtask

    // One complete access: IDLE(start) -> BUSY x (dly+1) -> DONE -> IDLE.
    task automatic access(input bit r, input bit w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rw, input int dly);
        bit ok = m_legal(r, w, f, a);
        exec = 1; re = r; we = w; f3 = f; addr = a; wdata = wd; mem_rdata = rw; mem_ack = 0;
        e_stall = 1; e_req = 0; e_fault = 0;
        @(posedge clk); #1;
        if (ok) begin
            e_req = 1; e_addr = {a[31:2], 2'b00}; e_be = m_be(f, a); e_we = w;
            e_wchk = w; e_wdata = m_lanes(f, wd);
            for (int i = 0; i <= dly; i++) begin
                mem_ack = (i == dly);
                @(posedge clk); #1;
            end
            mem_ack = 0;
            if (r) e_rdata = m_load(f, a, rw);
        end else begin
            e_fault = 1;
        end
        e_req = 0; e_stall = 0;
        @(posedge clk); #1;
        exec = 0; re = 0; we = 0; e_fault = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        model_reset();
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;

        // LB 0x103
        access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0);
        chk32("lb_rdata_lit", rdata, 32'hFFFF_FF80);
        chk32("lb_addr_lit", mem_addr, 32'h100);
        chk32("lb_be_lit", {28'd0, mem_be}, 32'h8);
        // SH 0x202
        access(0, 1, 3'd1, 32'h202, 32'hDEAD_BEEF, 32'h0, 0);
        chk32("sh_wdata_lit", mem_wdata, 32'hBEEF_BEEF);
        chk32("sh_be_lit", {28'd0, mem_be}, 32'hC);
        chk1 ("sh_we_lit", mem_we, 1'b1);
        // LHU 0x10, ack after 5 waiting cycles
        access(1, 0, 3'd5, 32'h10, 32'h0, 32'h1234_8765, 5);
        chk32("lhu_rdata_lit", rdata, 32'h0000_8765);
        access(1, 0, 3'd1, 32'h12, 32'h0, 32'h8001_0000, 1);
        access(1, 0, 3'd4, 32'h102, 32'h0, 32'h00FE_0000, 0);
        chk32("lbu_rdata_lit", rdata, 32'h0000_00FE);
        // LW at misaligned 0x6
        access(1, 0, 3'd2, 32'h6, 32'h0, 32'h5555_AAAA, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk32("lw6_rdata_kept", rdata, 32'h0000_00FE);
`else
        chk32("lw6_addr_lit", mem_addr, 32'h4);
        chk32("lw6_be_lit", {28'd0, mem_be}, 32'hF);
        chk32("lw6_rdata_lit", rdata, 32'h5555_AAAA);
`endif
        access(0, 1, 3'd0, 32'h7, 32'h1122_3344, 32'h0, 2);
        chk32("sb_wdata_lit", mem_wdata, 32'h4444_4444);
        access(0, 1, 3'd2, 32'h8, 32'hCAFE_F00D, 32'h0, 0);
        access(1, 0, 3'd1, 32'h13, 32'h0, 32'hABCD_0000, 0);
        // illegal: load f3=3, store f3=4, re&we
        access(1, 0, 3'd3, 32'h20, 32'h0, 32'h0, 0);
        access(0, 1, 3'd4, 32'h20, 32'h0, 32'h0, 0);
        access(1, 1, 3'd2, 32'h20, 32'h0, 32'h0, 0);
        // mem_ack while no request must be ignored
        mem_rdata = 32'hFFFF_FFFF; mem_ack = 1;
        repeat (2) @(posedge clk);
        #1 mem_ack = 0;
        access(1, 0, 3'd2, 32'h0, 32'h0, 32'h0123_4567, 0);

        // ---- timeout instance (TIMEOUT_CYCLES=4) ----
        exec4 = 1; re = 1; we = 0; f3 = 3'd4; addr = 32'h1; mem_rdata = 32'h0000_A500;
        @(posedge clk); #1 mem_ack4 = 1;
        @(negedge clk);
        chk1("t4_lbu_req", mem_req4, 1'b1);
        chk32("t4_lbu_be", {28'd0, mem_be4}, 32'h2);
        @(posedge clk); #1 mem_ack4 = 0;
        @(negedge clk);
        chk32("t4_lbu_rdata", rdata4, 32'h0000_00A5);
        chk1("t4_lbu_stall_done", stall4, 1'b0);
        @(posedge clk); #1 exec4 = 0; re = 0;
        @(posedge clk); #1;
        exec4 = 1; re = 1; f3 = 3'd2; addr = 32'h20;
        @(negedge clk);
        chk1("t4_start_stall", stall4, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("t4_busy_req", mem_req4, 1'b1);
            chk1("t4_busy_berr", bus_error4, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk1("t4_abort_req", mem_req4, 1'b0);
        chk1("t4_abort_berr", bus_error4, 1'b1);
        chk1("t4_abort_stall", stall4, 1'b0);
        chk32("t4_abort_rdata", rdata4, 32'h0000_00A5);
        @(posedge clk); #1 exec4 = 0; re = 0;
        @(negedge clk);
        chk1("t4_berr_once", bus_error4, 1'b0);
        @(posedge clk); #1;
        // ack in the same cycle the timeout expires: ack wins
        exec4 = 1; re = 1; f3 = 3'd2; addr = 32'h24; mem_rdata = 32'h600D_F00D;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            mem_ack4 = (i == 3);
            @(negedge clk);
            chk1("t4_race_req", mem_req4, 1'b1);
            @(posedge clk); #1;
        end
        mem_ack4 = 0;
        @(negedge clk);
        chk1("t4_race_berr", bus_error4, 1'b0);
        chk32("t4_race_rdata", rdata4, 32'h600D_F00D);
        @(posedge clk); #1 exec4 = 0; re = 0;
        @(posedge clk); #1;

        // ---- asynchronous reset in BUSY ----
        exec = 1; re = 1; we = 0; f3 = 3'd2; addr = 32'h40; mem_rdata = 32'h1111_2222;
        e_stall = 1; e_req = 0;
        @(posedge clk); #1;
        e_req = 1; e_addr = 32'h40; e_be = 4'hF; e_we = 0; e_wchk = 0;
        @(posedge clk); #1;
        chk_en = 0;
        #1 rst = 0;
        #1;
        chk1("arst_req", mem_req, 1'b0);
        chk1("arst_stall", stall, 1'b0);
        chk32("arst_addr", mem_addr, 32'h0);
        chk32("arst_rdata", rdata, 32'h0);
        exec = 0; re = 0;
        model_reset();
        @(posedge clk); #1 rst = 1;
        chk_en = 1;
        @(posedge clk); #1;
        access(1, 0, 3'd2, 32'h44, 32'h0, 32'h89AB_CDEF, 1);
        chk32("post_rst_lw_lit", rdata, 32'h89AB_CDEF);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-bus access stage driven by the control unit during its execute state. It turns the load/store strobes, `f3` and the ALU-computed address into one word-aligned, byte-enabled transaction on a req/ack data bus. It holds `stall` high until the transaction completes, which freezes the control unit's state machine. It returns sign- or zero-extended load data, registered and stable through write-back.

## Interface
- `TIMEOUT_CYCLES`, default 0: number of BUSY cycles without `mem_ack` before the access is aborted; 0 disables the timeout.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `exec` in 1: control unit is in its execute state.
- `re` in 1: load request (control unit `dbus_re`).
- `we` in 1: store request (control unit `dbus_we`).
- `f3` in 3: access width/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU; stores use 0/1/2.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data (rs2).
- `stall` out 1: hold the control unit.
- `rdata` out 32: extended load result.
- `access_fault` out 1: one-cycle pulse for an illegal `f3`, simultaneous `re`&`we`, or (with macro) a misaligned access.
- `bus_error` out 1: one-cycle pulse on timeout.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: word address; bits [1:0] are always 0.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: bus completion.
- `mem_rdata` in 32: bus read word, valid when `mem_ack` is high.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- An access is starting when `exec & (re|we)` is high and the FSM is in IDLE.
- `stall = (IDLE & starting) | BUSY`. `stall` is low in DONE.
- IDLE, starting, access legal: latch `mem_addr`, `mem_be`, `mem_we` and `mem_wdata`, then go to BUSY.
- IDLE, starting, access illegal: go to DONE and assert `access_fault` in DONE. No bus cycle occurs.
- BUSY: `mem_req` is high.
  - If `mem_ack` is high: latch `rdata` on a load, then go to DONE.
  - Else if the timeout expires: drop `mem_req`, go to DONE, and pulse `bus_error` in DONE. `rdata` is unchanged.
- DONE always goes to IDLE. `exec` may still be high in DONE but must not restart an access.
- Byte enables: B uses `1<<addr[1:0]`; H uses `3<<{addr[1],1'b0}`; W uses `4'hF`.
- Store data lanes: B replicates `wdata[7:0]` ×4; H replicates `wdata[15:0]` ×2; W passes `wdata` through.
- Load extraction: shift `mem_rdata` right by `8*addr[1:0]`, then sign-extend (f3 0/1) or zero-extend (f3 4/5) from bit 7 or 15.
- Illegal `f3`: loads with f3 3, 6 or 7; stores with f3 ≥ 3.
- `re` and `we` high together is always a fault.
- `mem_ack` is ignored while `mem_req` is low.

## Timing
- Reset values: FSM IDLE, `stall` 0 (outside `exec`), `rdata` 0, `access_fault` 0, `bus_error` 0, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_be` 0, `mem_wdata` 0, timeout counter 0.
- Asynchronous reset mid-BUSY drops `mem_req` immediately. The outstanding transaction is abandoned.
- Minimum latency is with `mem_ack` in the first BUSY cycle:
  - Cycle 0: IDLE, `stall` high.
  - Cycle 1: BUSY, `mem_req` high.
  - Cycle 2: DONE, `stall` low, `rdata` valid.
- `rdata` is held until the next load completes.
- `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are stable for the whole time `mem_req` is high.
- The timeout counter clears on entry to BUSY. The abort happens when the count reaches `TIMEOUT_CYCLES`, i.e. after `TIMEOUT_CYCLES` cycles in BUSY.
- If `mem_ack` arrives in the same cycle the timeout expires, `mem_ack` wins.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access is illegal: H/HU/SH with `addr[0]=1`, or W/SW with `addr[1:0]≠0`.
  - The FSM goes to DONE and `access_fault` pulses. No bus cycle occurs.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - H ignores `addr[0]`; W ignores `addr[1:0]`. The access is performed aligned-down.
  - `access_fault` is raised only for an illegal `f3` or simultaneous `re`&`we`.

## Test plan
- LB with `addr=0x103`, `mem_rdata=0x80FF_1234`, ack in the first BUSY cycle → `mem_addr=0x100`, `mem_be=4'b1000`, `stall` high for 2 cycles, `rdata=0xFFFF_FF80`.
- SH with `addr=0x202`, `wdata=0xDEAD_BEEF` → `mem_we=1`, `mem_be=4'b1100`, `mem_wdata=0xBEEF_BEEF`.
- LHU with `addr=0x10`, ack delayed 5 cycles → `mem_req` held 6 cycles with stable address, `stall` low in DONE, `rdata` zero-extended.
- `TIMEOUT_CYCLES=4`, no ack → `mem_req` drops after 4 BUSY cycles, `bus_error` pulses once, `rdata` is unchanged.
- LW at `addr=0x6`: with the macro, `access_fault` pulses and `mem_req` never rises; without it, `mem_addr=0x4` and `mem_be=4'hF`.
- Async reset asserted in BUSY → `mem_req` and `stall` go to 0 immediately; after release the next LW completes normally.
